// File: rtl/serial_subtractor.sv
// Purpose : bit-serial two's-complement subtractor, D = A - B, one bit per clock, LSB first.
// Latency : start accepted on E0, done pulses after E(WIDTH), ready again after E(WIDTH+1).
// Backpressure: start is honoured only while ready=1; requests in RUN/DONE are dropped, not queued.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request; A and B are sampled on the accepting edge only
//   A, B            minuend, subtrahend (WIDTH bits)
//   ready, busy     idle / subtraction in progress (decoded from the state register)
//   done            one-cycle pulse; D, B_out and V are valid from this cycle on
//   D               difference modulo 2^WIDTH, held until the next operation completes
//   B_out           unsigned borrow (A < B)
//   V               signed overflow
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             B_out,
   output logic             V
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             bw;
   logic [CW-1:0]    cnt;

   // Full-subtractor cell on the current LSBs.
   logic a_bit;
   logic b_bit;
   logic d_bit;
   logic bw_next;

   always_comb begin
      a_bit   = a_sh[0];
      b_bit   = b_sh[0];
      d_bit   = a_bit ^ b_bit ^ bw;
      bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
   end

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
         D      <= '0;
         B_out  <= 1'b0;
         V      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  bw    <= 1'b0;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end

            S_RUN: begin
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               bw     <= bw_next;
               if (cnt == LAST_BIT) begin
                  // On the last bit a_bit/b_bit are the operand sign bits, so
                  // overflow can be formed here without keeping the MSBs aside.
                  D     <= {d_bit, res_sh[WIDTH-1:1]};
                  B_out <= bw_next;
                  V     <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             B_out;
   logic             V;

   int checks;
   int errors;

   // Observations recorded by run_op for the test tasks to judge.
   int   lat;
   logic d_moved;
   logic busy_e0;
   logic ready_e0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .B_out (B_out),
      .V     (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one subtraction and waits (bounded) for done.
   // lat = number of edges after the accepting edge E0 at which done is seen, -1 on timeout.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d_prev;
      int n;
      @(negedge clk);
      start = 1'b1;
      A     = a;
      B     = b;
      @(negedge clk);               // after E0
      start    = 1'b0;
      A        = ~a;                // operands must not be re-sampled
      B        = a ^ 8'h5A;
      busy_e0  = busy;
      ready_e0 = ready;
      d_prev   = D;
      d_moved  = 1'b0;
      n        = 0;
      while (!done && n < 40) begin
         if (D !== d_prev) d_moved = 1'b1;
         @(negedge clk);
         n++;
      end
      lat = done ? n : -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL reset_flags got ready/busy/done=%b want 100", {ready, busy, done});
      end
      checks++;
      if ({D, B_out, V} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs got D=%h B_out=%b V=%b want 00/0/0", D, B_out, V);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      run_op(8'h05, 8'h03);
      checks++;
      if ({busy_e0, ready_e0} !== 2'b10) begin
         errors++;
         $display("FAIL basic_e0_flags got busy/ready=%b%b want 10", busy_e0, ready_e0);
      end
      checks++;
      if (lat !== WIDTH) begin
         errors++;
         $display("FAIL basic_latency got %0d want %0d", lat, WIDTH);
      end
      checks++;
      if ({D, B_out, V} !== {8'h02, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result got D=%h B_out=%b V=%b want 02/0/0", D, B_out, V);
      end
      @(negedge clk);
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL basic_return got ready/busy/done=%b want 100", {ready, busy, done});
      end
   endtask

   task automatic test_borrow;
      run_op(8'h03, 8'h05);
      checks++;
      if (d_moved !== 1'b0) begin
         errors++;
         $display("FAIL borrow_d_stable got D change during run want none");
      end
      checks++;
      if ({D, B_out, V} !== {8'hFE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL borrow_result got D=%h B_out=%b V=%b want FE/1/0", D, B_out, V);
      end
   endtask

   task automatic test_overflow;
      run_op(8'h80, 8'h01);
      checks++;
      if ({D, B_out, V} !== {8'h7F, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ovf_neg got D=%h B_out=%b V=%b want 7F/0/1", D, B_out, V);
      end
      run_op(8'h7F, 8'hFF);
      checks++;
      if ({D, B_out, V} !== {8'h80, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL ovf_pos got D=%h B_out=%b V=%b want 80/1/1", D, B_out, V);
      end
   endtask

   task automatic test_equal;
      run_op(8'h00, 8'h00);
      checks++;
      if ({D, B_out, V} !== {8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL eq_zero got D=%h B_out=%b V=%b want 00/0/0", D, B_out, V);
      end
      run_op(8'hFF, 8'hFF);
      checks++;
      if ({D, B_out, V} !== {8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL eq_ones got D=%h B_out=%b V=%b want 00/0/0", D, B_out, V);
      end
   endtask

   // start held high, operands changing every cycle: only the accepted operands
   // count, and dones are spaced WIDTH+2 edges apart.
   task automatic test_back_to_back;
      int first_k;
      int second_k;
      int n_done;
      logic [7:0] d_first;
      first_k  = -1;
      second_k = -1;
      n_done   = 0;
      d_first  = '0;
      @(negedge clk);
      start = 1'b1;
      A     = 8'h10;
      B     = 8'h01;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);            // after E_k
         if (done) begin
            n_done++;
            if (first_k < 0) begin
               first_k = k;
               d_first = D;
            end else if (second_k < 0) begin
               second_k = k;
            end
         end
         A = 8'(k * 7 + 3);
         B = 8'(k * 3 + 1);
      end
      start = 1'b0;
      checks++;
      if (first_k !== WIDTH) begin
         errors++;
         $display("FAIL b2b_first_done got edge %0d want %0d", first_k, WIDTH);
      end
      checks++;
      if (d_first !== 8'h0F) begin
         errors++;
         $display("FAIL b2b_first_result got D=%h want 0F", d_first);
      end
      checks++;
      if (second_k - first_k !== WIDTH + 2) begin
         errors++;
         $display("FAIL b2b_period got %0d want %0d", second_k - first_k, WIDTH + 2);
      end
      checks++;
      if (n_done !== 3) begin
         errors++;
         $display("FAIL b2b_done_count got %0d want 3", n_done);
      end
      repeat (WIDTH + 3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int n_done;
      run_op(8'h55, 8'h11);
      checks++;
      if (D !== 8'h44) begin
         errors++;
         $display("FAIL abort_setup got D=%h want 44", D);
      end
      @(negedge clk);
      start = 1'b1;
      A     = 8'h3C;
      B     = 8'h0F;
      @(negedge clk);               // after E0
      start = 1'b0;
      repeat (4) @(negedge clk);    // after E4: bit 4 is the next to be processed
      n_done = 0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({D, B_out, V} !== 10'd0) begin
         errors++;
         $display("FAIL abort_outputs got D=%h B_out=%b V=%b want 00/0/0", D, B_out, V);
      end
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL abort_flags got ready/busy/done=%b want 100", {ready, busy, done});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d done pulses want 0", n_done);
      end
      run_op(8'h3C, 8'h0F);
      checks++;
      if (lat !== WIDTH) begin
         errors++;
         $display("FAIL fresh_latency got %0d want %0d", lat, WIDTH);
      end
      checks++;
      if ({D, B_out, V} !== {8'h2D, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fresh_result got D=%h B_out=%b V=%b want 2D/0/0", D, B_out, V);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      lat      = 0;
      d_moved  = 1'b0;
      busy_e0  = 1'b0;
      ready_e0 = 1'b0;
      test_reset();
      test_basic();
      test_borrow();
      test_overflow();
      test_equal();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
